dcache_responder: RTL and testbench

Direct-mapped, write-back L1 data cache that is the responder on the CPU datapath's dmem port. It accepts word-granular load/store requests in the MEM stage and returns load data in the following (WB) cycle. It fetches and evicts 256-bit lines over a burst physical-memory port. It sits between the pipelined datapath and the memory arbiter.

---
 rtl/dcache_responder_if.sv | 37 +++
 rtl/dcache_responder.sv | 167 ++++++++++++++++
 tb/tb_dcache_responder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_responder_if.sv
// dcache_responder_if: bundles the CPU-side dmem port and the burst pmem port of the L1 data
// cache.
//   slave  modport: the cache view. dmem requests and pmem fill data/resp are inputs; dmem
//                   resp/ready/rdata and the pmem strobes, address and wdata are outputs.
//   master modport: the environment view (CPU datapath plus memory arbiter), the mirror image.
`timescale 1ns/1ps
interface dcache_responder_if;
  logic         dmem_read;
  logic         dmem_write;
  logic [31:0]  dmem_address;
  logic [3:0]   dmem_byte_enable;
  logic [31:0]  dmem_wdata;
  logic         dmem_stall;
  logic         dmem_resp;
  logic         dmem_ready;
  logic [31:0]  dmem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_byte_enable, dmem_wdata, dmem_stall,
    input  pmem_rdata, pmem_resp,
    output dmem_resp, dmem_ready, dmem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_byte_enable, dmem_wdata, dmem_stall,
    output pmem_rdata, pmem_resp,
    input  dmem_resp, dmem_ready, dmem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped, write-back, write-allocate L1 data cache with 256-bit lines.
// Hits answer with dmem_resp in the request cycle; load data is registered and presented with
// dmem_ready one cycle later. Misses evict a dirty victim, then fill over the burst pmem port.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   bus         - dcache_responder_if.slave (dmem request/response, pmem burst port)
//   hit_count, miss_count - 32-bit wrapping performance counters, only when the
//                 DCACHE_PERF_EN macro is defined
`timescale 1ns/1ps
module dcache_responder #(
  parameter int unsigned SETS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dcache_responder_if.slave     bus
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);
  localparam int unsigned IW = $clog2(SETS);
  localparam int unsigned TW = 32 - IW - 5;

  typedef enum logic [1:0] {StLookup, StWriteback, StFill} state_e;

  state_e          r_state, w_state_next;
  logic [SETS-1:0] r_valid, r_dirty;
  logic [TW-1:0]   r_tag  [SETS];
  logic [255:0]    r_data [SETS];
  logic            r_ready;
  logic [31:0]     r_rdata;

  logic [IW-1:0]   w_index;
  logic [TW-1:0]   w_tag;
  logic [2:0]      w_offset;
  logic [7:0]      w_word_lsb;
  logic            w_req, w_hit, w_accept_hit, w_miss_start;
  logic            w_resp, w_pmem_read, w_pmem_write;
  logic [31:0]     w_pmem_address;
  logic [255:0]    w_pmem_wdata;
  logic [255:0]    w_line, w_merged;
  logic [31:0]     w_rd_word;
  logic            w_unused_addr;

  assign w_index       = bus.dmem_address[IW+4:5];
  assign w_tag         = bus.dmem_address[31:IW+5];
  assign w_offset      = bus.dmem_address[4:2];
  assign w_word_lsb    = {w_offset, 5'b0};
  assign w_unused_addr = ^bus.dmem_address[1:0];

  assign w_req     = bus.dmem_read | bus.dmem_write;
  assign w_hit     = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_line    = r_data[w_index];
  assign w_rd_word = w_line[w_word_lsb +: 32];

  // Store data merged into the current line; written back whole on an accepted write hit.
  always_comb begin
    logic [7:0] lsb;
    w_merged = w_line;
    lsb      = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      lsb = w_word_lsb + 8'(8 * b);
      if (bus.dmem_byte_enable[b]) w_merged[lsb +: 8] = bus.dmem_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StLookup;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    w_resp         = 1'b0;
    w_miss_start   = 1'b0;
    w_pmem_read    = 1'b0;
    w_pmem_write   = 1'b0;
    w_pmem_address = '0;
    w_pmem_wdata   = '0;
    unique case (r_state)
      StLookup: begin
        // A stalled CPU gets no acceptance and starts no miss.
        if (!bus.dmem_stall) begin
          if (!w_req || w_hit) begin
            w_resp = 1'b1;
          end else begin
            w_miss_start = 1'b1;
            w_state_next = (r_valid[w_index] && r_dirty[w_index]) ? StWriteback : StFill;
          end
        end
      end
      StWriteback: begin
        w_pmem_write   = 1'b1;
        w_pmem_address = {r_tag[w_index], w_index, 5'b0};
        w_pmem_wdata   = w_line;
        if (bus.pmem_resp) w_state_next = StFill;
      end
      StFill: begin
        w_pmem_read    = 1'b1;
        w_pmem_address = {w_tag, w_index, 5'b0};
        if (bus.pmem_resp) w_state_next = StLookup;
      end
      default: w_state_next = StLookup;
    endcase
  end

  assign w_accept_hit = (r_state == StLookup) && !bus.dmem_stall && w_req && w_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (r_state == StFill && bus.pmem_resp) begin
        r_valid[w_index] <= 1'b1;
        r_dirty[w_index] <= 1'b0;
      end else if (r_state == StWriteback && bus.pmem_resp) begin
        r_dirty[w_index] <= 1'b0;
      end else if (w_accept_hit && bus.dmem_write) begin
        r_dirty[w_index] <= 1'b1;
      end
      // WB-side outputs freeze while the CPU is stalled.
      if (!bus.dmem_stall) begin
        r_ready <= w_accept_hit && bus.dmem_read;
        if (w_accept_hit && bus.dmem_read) r_rdata <= w_rd_word;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (r_state == StFill && bus.pmem_resp) begin
      r_tag[w_index]  <= w_tag;
      r_data[w_index] <= bus.pmem_rdata;
    end else if (w_accept_hit && bus.dmem_write) begin
      r_data[w_index] <= w_merged;
    end
  end

  assign bus.dmem_resp    = w_resp;
  assign bus.dmem_ready   = r_ready;
  assign bus.dmem_rdata   = r_rdata;
  assign bus.pmem_read    = w_pmem_read;
  assign bus.pmem_write   = w_pmem_write;
  assign bus.pmem_address = w_pmem_address;
  assign bus.pmem_wdata   = w_pmem_wdata;

`ifdef DCACHE_PERF_EN
  logic [31:0] r_hit_count, r_miss_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_accept_hit) r_hit_count  <= r_hit_count + 32'd1;
      if (w_miss_start) r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif
endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder with a behavioural burst memory on the pmem port.
`timescale 1ns/1ps
module tb_dcache_responder;
  localparam int unsigned LAT   = 5;    // strobe-high cycles before pmem_resp pulses
  localparam int          LIMIT = 100;  // per-request cycle budget

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_responder_if bus ();

`ifdef DCACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  dcache_responder #(.SETS(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DCACHE_PERF_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Memory model: line i holds words equal to their own byte address, except line 0x1000
  // whose word1 is 0xDEADBEEF. Completed transactions are logged in order.
  logic [255:0] mem [1024];
  int unsigned  cnt;
  bit           both_high;
  bit           log_wr   [$];
  logic [31:0]  log_addr [$];
  logic [255:0] log_data [$];

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(4 * i);
    return l;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= 0;
      both_high      <= 1'b0;
      bus.pmem_resp  <= 1'b0;
      bus.pmem_rdata <= '0;
      for (int i = 0; i < 1024; i++) mem[i] <= make_line(32'(i * 32));
      mem[128][63:32] <= 32'hDEADBEEF;
    end else begin
      bus.pmem_resp <= 1'b0;
      if (bus.pmem_read && bus.pmem_write) both_high <= 1'b1;
      if ((bus.pmem_read || bus.pmem_write) && !bus.pmem_resp) begin
        if (cnt == LAT - 1) begin
          cnt           <= 0;
          bus.pmem_resp <= 1'b1;
          if (bus.pmem_read) bus.pmem_rdata <= mem[bus.pmem_address[14:5]];
          else               mem[bus.pmem_address[14:5]] <= bus.pmem_wdata;
          log_wr.push_back(bus.pmem_write);
          log_addr.push_back(bus.pmem_address);
          log_data.push_back(bus.pmem_wdata);
        end else begin
          cnt <= cnt + 1;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge with requests dropped.
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd, output int waited);
    bus.dmem_read        = rd;
    bus.dmem_write       = wr;
    bus.dmem_address     = addr;
    bus.dmem_byte_enable = be;
    bus.dmem_wdata       = wd;
    waited = 0;
    forever begin
      #1;
      if (bus.dmem_resp === 1'b1 || waited >= LIMIT) break;
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    bus.dmem_read  = 1'b0;
    bus.dmem_write = 1'b0;
  endtask

  task automatic test_reset();
    bus.dmem_read = 0; bus.dmem_write = 0; bus.dmem_address = 0;
    bus.dmem_byte_enable = 0; bus.dmem_wdata = 0; bus.dmem_stall = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.dmem_resp !== 1'b1) begin errors++;
      $display("FAIL reset_resp got %0h want 1", bus.dmem_resp); end
    checks++; if (bus.dmem_ready !== 1'b0) begin errors++;
      $display("FAIL reset_ready got %0h want 0", bus.dmem_ready); end
    checks++; if (bus.dmem_rdata !== 32'h0) begin errors++;
      $display("FAIL reset_rdata got %h want 0", bus.dmem_rdata); end
    checks++; if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin errors++;
      $display("FAIL reset_strobes got rd=%0h wr=%0h want 0/0", bus.pmem_read, bus.pmem_write); end
    checks++; if (bus.pmem_address !== 32'h0 || bus.pmem_wdata !== 256'h0) begin errors++;
      $display("FAIL reset_pmem_bus got addr=%h want 0 and zero wdata", bus.pmem_address); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cold_read();
    int w;
    int n0 = log_addr.size();
    do_req(1, 0, 32'h0000_1004, 4'h0, 32'h0, w);
    checks++; if (w != 7) begin errors++;
      $display("FAIL cold_latency got %0d want 7", w); end
    checks++; if (bus.dmem_ready !== 1'b1 || bus.dmem_rdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL cold_rdata got ready=%0h data=%h want 1/deadbeef",
               bus.dmem_ready, bus.dmem_rdata); end
    checks++; if (log_addr.size() != n0 + 1 || log_wr[n0] !== 1'b0
                  || log_addr[n0] !== 32'h0000_1000) begin errors++;
      $display("FAIL cold_fill got %0d txns addr=%h want one read of 00001000",
               log_addr.size() - n0, log_addr[n0]); end
  endtask

  task automatic test_write_hit();
    int w;
    do_req(0, 1, 32'h0000_1004, 4'b0010, 32'h0000AB00, w);
    checks++; if (w != 0) begin errors++;
      $display("FAIL write_hit_latency got %0d want 0", w); end
    checks++; if (bus.dmem_ready !== 1'b0) begin errors++;
      $display("FAIL ready_after_write got %0h want 0", bus.dmem_ready); end
    do_req(1, 0, 32'h0000_1004, 4'h0, 32'h0, w);
    checks++; if (w != 0 || bus.dmem_ready !== 1'b1 || bus.dmem_rdata !== 32'hDEADABEF)
    begin errors++;
      $display("FAIL store_load got wait=%0d ready=%0h data=%h want 0/1/deadabef",
               w, bus.dmem_ready, bus.dmem_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4] = '{32'h1000, 32'h1008, 32'h101C, 32'h1004};
    logic [31:0] exps  [4] = '{32'h1000, 32'h1008, 32'h101C, 32'hDEADABEF};
    int w;
    for (int i = 0; i < 4; i++) begin
      do_req(1, 0, addrs[i], 4'h0, 32'h0, w);
      checks++; if (w != 0 || bus.dmem_ready !== 1'b1 || bus.dmem_rdata !== exps[i])
      begin errors++;
        $display("FAIL b2b_%0d got wait=%0d ready=%0h data=%h want 0/1/%h",
                 i, w, bus.dmem_ready, bus.dmem_rdata, exps[i]); end
    end
  endtask

  task automatic test_stall();
    bus.dmem_stall   = 1'b1;
    bus.dmem_read    = 1'b1;
    bus.dmem_address = 32'h0000_1008;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.dmem_resp !== 1'b0) begin errors++;
        $display("FAIL stall_resp_%0d got %0h want 0", i, bus.dmem_resp); end
      @(negedge clk);
      checks++; if (bus.dmem_ready !== 1'b1 || bus.dmem_rdata !== 32'hDEADABEF) begin errors++;
        $display("FAIL stall_hold_%0d got ready=%0h data=%h want 1/deadabef",
                 i, bus.dmem_ready, bus.dmem_rdata); end
    end
    bus.dmem_stall = 1'b0;
    bus.dmem_read  = 1'b0;
    #1;
    checks++; if (bus.dmem_resp !== 1'b1) begin errors++;
      $display("FAIL release_resp got %0h want 1", bus.dmem_resp); end
    @(negedge clk);
    checks++; if (bus.dmem_ready !== 1'b0 || bus.dmem_rdata !== 32'hDEADABEF) begin errors++;
      $display("FAIL idle_ready got ready=%0h data=%h want 0/deadabef",
               bus.dmem_ready, bus.dmem_rdata); end
  endtask

  task automatic test_conflict();
    int w;
    int n0 = log_addr.size();
    logic [255:0] wb_line;
    logic [31:0]  wb_word1;
    do_req(1, 0, 32'h0000_1104, 4'h0, 32'h0, w);
    checks++; if (w != 13) begin errors++;
      $display("FAIL dirty_miss_latency got %0d want 13", w); end
    checks++; if (bus.dmem_ready !== 1'b1 || bus.dmem_rdata !== 32'h0000_1104) begin errors++;
      $display("FAIL conflict_rdata got ready=%0h data=%h want 1/00001104",
               bus.dmem_ready, bus.dmem_rdata); end
    checks++; if (log_addr.size() != n0 + 2) begin errors++;
      $display("FAIL conflict_txn_count got %0d want 2", log_addr.size() - n0); end
    wb_line  = log_data[n0];
    wb_word1 = wb_line[63:32];
    checks++; if (log_wr[n0] !== 1'b1 || log_addr[n0] !== 32'h0000_1000
                  || wb_word1 !== 32'hDEADABEF) begin errors++;
      $display("FAIL writeback got wr=%0h addr=%h word1=%h want 1/00001000/deadabef",
               log_wr[n0], log_addr[n0], wb_word1); end
    checks++; if (log_wr[n0+1] !== 1'b0 || log_addr[n0+1] !== 32'h0000_1100) begin errors++;
      $display("FAIL refill got wr=%0h addr=%h want 0/00001100", log_wr[n0+1], log_addr[n0+1]);
    end
    checks++; if (both_high !== 1'b0) begin errors++;
      $display("FAIL strobe_overlap got %0h want 0", both_high); end
    // Evicted data must come back from memory.
    do_req(1, 0, 32'h0000_1004, 4'h0, 32'h0, w);
    checks++; if (w != 7 || bus.dmem_rdata !== 32'hDEADABEF) begin errors++;
      $display("FAIL reload_evicted got wait=%0d data=%h want 7/deadabef", w, bus.dmem_rdata);
    end
  endtask

  task automatic test_reset_mid_fill();
    int w;
    int n = 0;
    bus.dmem_read    = 1'b1;
    bus.dmem_address = 32'h0000_2024;
    while (bus.pmem_read !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
    checks++; if (bus.pmem_read !== 1'b1) begin errors++;
      $display("FAIL fill_start got pmem_read=%0h want 1", bus.pmem_read); end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.pmem_read !== 1'b0 || bus.pmem_address !== 32'h0) begin errors++;
      $display("FAIL async_drop got rd=%0h addr=%h want 0/0", bus.pmem_read, bus.pmem_address);
    end
    bus.dmem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1, 0, 32'h0000_2024, 4'h0, 32'h0, w);
    checks++; if (w != 7 || bus.dmem_rdata !== 32'h0000_2024) begin errors++;
      $display("FAIL post_reset_miss got wait=%0d data=%h want 7/00002024", w, bus.dmem_rdata);
    end
  endtask

`ifdef DCACHE_PERF_EN
  task automatic test_perf();
    logic [31:0] addrs [4] = '{32'h3000, 32'h3004, 32'h3008, 32'h300C};
    int w;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin errors++;
      $display("FAIL perf_reset got hit=%0d miss=%0d want 0/0", hit_count, miss_count); end
    for (int i = 0; i < 4; i++) do_req(1, 0, addrs[i], 4'h0, 32'h0, w);
    checks++; if (hit_count !== 32'd4 || miss_count !== 32'd1) begin errors++;
      $display("FAIL perf_counts got hit=%0d miss=%0d want 4/1", hit_count, miss_count); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cold_read();
    test_write_hit();
    test_back_to_back();
    test_stall();
    test_conflict();
    test_reset_mid_fill();
`ifdef DCACHE_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
